frame_buf_mem_resp: RTL and testbench
=====================================

// Module: frame_buf_mem_resp
// PURPOSE
//  Memory-side responder for the frame buffer address generator. Accepts its active-low
//  wr_en/rd_en requests and addresses, and returns wr_rdy/rd_rdy handshakes and read data.
//  Storage is an inferred single-port RAM. Used as the on-chip memory for the frame buffer
//  and as the bench memory model standing in for the DDR interface.
// PARAMETERS
//  DATA_WIDTH  32      data word width
//  ADDR_WIDTH  29      request address width
//  BASE_ADDR   2       first valid address
//  BUF_SIZE    230400  last valid address is BASE_ADDR+BUF_SIZE (inclusive)
//  LOCAL_AW    18      RAM index width; 2**LOCAL_AW must be >= BUF_SIZE+1
//  RD_LATENCY  2       cycles from read accept to rd_data_valid; legal range 1..8
// PORTS
//  clk            in   1           single clock, all logic on posedge
//  reset          in   1           synchronous, active-high
//  wr_en          in   1           write request, active-low
//  wr_addr        in   ADDR_WIDTH  write address
//  wr_data        in   DATA_WIDTH  write data
//  wr_rdy         out  1           write accepted this cycle (combinational)
//  rd_en          in   1           read request, active-low
//  rd_addr        in   ADDR_WIDTH  read address
//  rd_rdy         out  1           read accepted this cycle (combinational)
//  rd_data        out  DATA_WIDTH  read data
//  rd_data_valid  out  1           rd_data valid, 1-cycle pulse per accepted read
//  addr_err       out  1           sticky out-of-range access flag
// BEHAVIOUR
//  - Reset (clk edge with reset=1): rd_data_valid=0, rd_data=0, addr_err=0, last_grant=READ.
//    The read pipeline is flushed; RAM contents are preserved. wr_rdy=rd_rdy=0 while reset=1.
//  - Accept rule: at most one request per cycle.
//    wr_rdy = ~reset & ~wr_en & grant_w & ~stall
//    rd_rdy = ~reset & ~rd_en & grant_r & ~stall
//    A request held without rdy stays pending; the master keeps address and data stable.
//  - Arbiter, round-robin:
//    * Only one request pending: that request is granted.
//    * Both pending: the side opposite last_grant is granted.
//    * last_grant updates only on an actual accept.
//    * After reset, writes win the first collision.
//  - Index: idx = addr - BASE_ADDR, truncated to LOCAL_AW bits.
//    in_range = (addr >= BASE_ADDR) && (addr <= BASE_ADDR+BUF_SIZE).
//  - Accepted write, in range: RAM[idx] <= wr_data at the accepting edge.
//  - Accepted write, out of range: data dropped; addr_err <= 1.
//  - Accepted read: enters a RD_LATENCY-deep valid/data shift pipeline.
//    rd_data_valid=1 exactly RD_LATENCY cycles after the rd_rdy cycle.
//    Reads are in order and fully pipelined (one per cycle sustained).
//  - Accepted read, out of range: returns 0 with valid=1; addr_err <= 1.
//  - rd_data holds its last value when valid=0.
//  - Write-then-read of the same address on consecutive accepts returns the new data.
//  - addr_err clears only on reset.
//  - State: last_grant (1b), stall LFSR, pipeline regs. There is no other FSM; the arbiter
//    is IDLE/W/R per cycle.
// CONFIGURATION
//  MEM_RESP_STALL_EN defined:
//    - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1, reset to seed, steps every cycle.
//    - stall = (lfsr[1:0]==2'b00), about 25% of cycles.
//    - Neither side is accepted in a stalled cycle.
//  Not defined: stall=0 constant, no LFSR logic is generated.
// TESTING
//  T1 reset=1 for 2 cycles with wr_en=rd_en=0 -> wr_rdy=rd_rdy=0; valid=0; addr_err=0.
//  T2 write 32'hDEADBEEF @2, then read @2 -> valid exactly 2 cycles after rd_rdy; data=DEADBEEF.
//  T3 wr_en=rd_en=0 for 4 cycles, distinct in-range addrs -> accepts W,R,W,R; valid for each read.
//  T4 write @230403 -> wr_rdy=1, addr_err=1 next cycle; read @1 -> rd_data=0, valid=1.
//  T5 reset pulse while 2 reads in flight -> no valid pulse follows; RAM data @2 is retained.
//  T6 MEM_RESP_STALL_EN, wr_en held low 1000 cycles -> 700..800 accepts; readback matches.

Source files
------------

// File: rtl/frame_buf_mem_resp.sv
// frame_buf_mem_resp
// Memory-side responder for the frame buffer address generator. Takes active-low
// write/read requests, grants at most one per cycle with a round-robin arbiter,
// stores writes in an inferred single-port RAM and returns read data through a
// fixed-latency pipeline. Out-of-range accesses raise a sticky addr_err.
// Optional build macro MEM_RESP_STALL_EN inserts pseudo-random stall cycles
// (16-bit LFSR) during which no request is accepted.
module frame_buf_mem_resp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 29,
  parameter int BASE_ADDR  = 2,
  parameter int BUF_SIZE   = 230400,
  parameter int LOCAL_AW   = 18,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_rdy,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_rdy,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic                  addr_err
);

  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(BASE_ADDR + BUF_SIZE);

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_e;

  grant_e last_grant, last_grant_nxt;

  logic wr_pend, rd_pend;
  logic grant_w, grant_r;
  logic wr_acc, rd_acc;
  logic stall;

  logic                wr_in_range, rd_in_range;
  logic [LOCAL_AW-1:0] wr_idx, rd_idx;

  logic [DATA_WIDTH-1:0] ram [2**LOCAL_AW];

  logic [RD_LATENCY-1:0] vld_pipe;
  logic [DATA_WIDTH-1:0] dat_pipe [RD_LATENCY];

`ifdef MEM_RESP_STALL_EN
  logic [15:0] lfsr;

  // Stall generator: Fibonacci LFSR, taps 16,14,13,11, stepping every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Address decode: range check and RAM index relative to BASE_ADDR.
  assign wr_in_range = (wr_addr >= FIRST_ADDR) && (wr_addr <= LAST_ADDR);
  assign rd_in_range = (rd_addr >= FIRST_ADDR) && (rd_addr <= LAST_ADDR);
  assign wr_idx      = LOCAL_AW'(wr_addr - FIRST_ADDR);
  assign rd_idx      = LOCAL_AW'(rd_addr - FIRST_ADDR);

  // Arbiter: single requester wins; on collision the side opposite last_grant wins.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves it unassigned (no latch).
    wr_pend        = ~wr_en;
    rd_pend        = ~rd_en;
    grant_w        = 1'b0;
    grant_r        = 1'b0;
    wr_acc         = 1'b0;
    rd_acc         = 1'b0;
    last_grant_nxt = last_grant;

    grant_w = wr_pend & (~rd_pend | (last_grant == GRANT_READ));
    grant_r = rd_pend & (~wr_pend | (last_grant == GRANT_WRITE));
    wr_acc  = ~reset & grant_w & ~stall;
    rd_acc  = ~reset & grant_r & ~stall;

    if (wr_acc) begin
      last_grant_nxt = GRANT_WRITE;
    end else if (rd_acc) begin
      last_grant_nxt = GRANT_READ;
    end
  end

  assign wr_rdy = wr_acc;
  assign rd_rdy = rd_acc;

  // Arbiter state: remembers which side was accepted most recently.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      last_grant <= GRANT_READ;
    end else begin
      last_grant <= last_grant_nxt;
    end
  end

  // RAM write port: accepted in-range writes land at the accepting edge.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset so it maps onto block RAM and keeps its contents across reset.
    if (wr_acc && wr_in_range) begin
      ram[wr_idx] <= wr_data;
    end
  end

  // Read pipeline and error flag: RAM read at accept, then RD_LATENCY-1 shift stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        dat_pipe[k] <= '0;
      end
      addr_err <= 1'b0;
    end else begin
      vld_pipe[0] <= rd_acc;
      if (rd_acc) begin
        dat_pipe[0] <= rd_in_range ? ram[rd_idx] : '0;
      end
      // Data stages only move with a valid word so the output holds between reads.
      for (int k = 1; k < RD_LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) begin
          dat_pipe[k] <= dat_pipe[k-1];
        end
      end
      if ((wr_acc && !wr_in_range) || (rd_acc && !rd_in_range)) begin
        addr_err <= 1'b1;
      end
    end
  end

  assign rd_data_valid = vld_pipe[RD_LATENCY-1];
  assign rd_data       = dat_pipe[RD_LATENCY-1];

endmodule

// File: tb/tb_frame_buf_mem_resp.sv
// tb_frame_buf_mem_resp
// Scoreboard bench for frame_buf_mem_resp. The stimulus side predicts grants from
// the round-robin rule and a sparse memory model, pushing expected read words with
// their due cycle; an independent monitor pops them when rd_data_valid is seen.
module tb_frame_buf_mem_resp;

  localparam int DW   = 32;
  localparam int AW   = 29;
  localparam int BASE = 2;
  localparam int BSZ  = 230400;
  localparam int LAT  = 2;
  localparam int LAST = BASE + BSZ;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_rdy;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_rdy;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          addr_err;

  frame_buf_mem_resp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE),
    .BUF_SIZE(BSZ), .LOCAL_AW(18), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rst_seen;

  always @(posedge clk) cyc = cyc + 1;
  always @(posedge clk) rst_seen <= reset;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q[$];
  bit [DW-1:0]   mem [int];
  bit            last_w = 1'b0;
  bit            err_exp = 1'b0;
  bit            last_aw, last_ar;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_rng(int a);
    return (a >= BASE) && (a <= LAST);
  endfunction

  // One clock cycle: predict grants, compare handshakes, update the model.
  task automatic step();
    bit   wp, rp, gw, gr, aw, ar;
    exp_t e;
    exp_t keep[$];
    @(negedge clk);
    wp = !wr_en;
    rp = !rd_en;
    if (reset) begin
      gw = 1'b0;
      gr = 1'b0;
    end else begin
      gw = wp && (!rp || !last_w);
      gr = rp && !gw;
    end
`ifdef MEM_RESP_STALL_EN
    check("wr_rdy_illegal", wr_rdy & ~gw, 0);
    check("rd_rdy_illegal", rd_rdy & ~gr, 0);
    aw = gw && wr_rdy;
    ar = gr && rd_rdy;
`else
    check("wr_rdy", wr_rdy, gw);
    check("rd_rdy", rd_rdy, gr);
    aw = gw;
    ar = gr;
`endif
    check("addr_err", addr_err, err_exp);
    if (reset) begin
      last_w  = 1'b0;
      err_exp = 1'b0;
      foreach (q[i]) if (q[i].due <= cyc) keep.push_back(q[i]);
      q = keep;
    end else begin
      if (aw) begin
        last_w = 1'b1;
        if (in_rng(int'(wr_addr))) mem[int'(wr_addr)] = wr_data;
        else err_exp = 1'b1;
      end
      if (ar) begin
        last_w = 1'b0;
        e.due  = cyc + LAT;
        e.data = '0;
        if (in_rng(int'(rd_addr))) begin
          if (mem.exists(int'(rd_addr))) e.data = mem[int'(rd_addr)];
        end else begin
          err_exp = 1'b1;
        end
        q.push_back(e);
      end
    end
    last_aw = aw;
    last_ar = ar;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(int a, logic [DW-1:0] d);
    bit done = 1'b0;
    wr_en = 1'b0; wr_addr = AW'(a); wr_data = d;
    for (int i = 0; i < 64 && !done; i++) begin
      step();
      done = last_aw;
    end
    if (!done) check("write_timeout", 0, 1);
    wr_en = 1'b1;
  endtask

  task automatic do_read(int a);
    bit done = 1'b0;
    rd_en = 1'b0; rd_addr = AW'(a);
    for (int i = 0; i < 64 && !done; i++) begin
      step();
      done = last_ar;
    end
    if (!done) check("read_timeout", 0, 1);
    rd_en = 1'b1;
  endtask

  function automatic int rand_addr();
    int r = $urandom_range(9, 0);
    if (r <= 6) return BASE + $urandom_range(15, 0);
    if (r == 7) return LAST - $urandom_range(1, 0);
    if (r == 8) return LAST + 1;
    return $urandom_range(1, 0);
  endfunction

  // Monitor: compares every valid word against the scoreboard and checks hold/flush.
  logic [DW-1:0] hold_data = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        check("rd_valid_in_reset", rd_data_valid, 0);
        check("rd_data_after_reset", rd_data, 0);
        hold_data = '0;
      end else if (rd_data_valid) begin
        if (q.size() == 0) begin
          check("rd_valid_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          check("rd_latency_cycle", cyc, e.due);
          check("rd_data", rd_data, e.data);
          hold_data = e.data;
        end
      end else begin
        check("rd_data_hold", rd_data, hold_data);
        if (q.size() > 0 && q[0].due <= cyc) begin
          check("rd_valid_missing", rd_data_valid, 1);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    // T1: reset with both requests asserted.
    step();
    step();
    reset = 1'b0; wr_en = 1'b1; rd_en = 1'b1;
    step();

    // T2: write then read the first valid address.
    do_write(BASE, 32'hDEADBEEF);
    do_read(BASE);
    repeat (4) step();

    // T3: both requests held; arbitration alternates W,R,W,R.
    wr_en = 1'b0; wr_addr = AW'(10); wr_data = 32'h1111_0010;
    rd_en = 1'b0; rd_addr = AW'(10);
    for (int i = 0; i < 4; i++) begin
      step();
      if (last_aw) begin wr_addr = AW'(11); wr_data = 32'h2222_0011; end
      if (last_ar) rd_addr = AW'(11);
    end
    wr_en = 1'b1; rd_en = 1'b1;
    repeat (4) step();

    // T4: range boundaries and out-of-range accesses.
    do_write(LAST, 32'hCAFE_F00D);
    do_read(LAST);
    step();
    do_write(LAST + 1, 32'h0BAD_0BAD);
    step();
    do_read(1);
    do_read(LAST + 1);
    repeat (4) step();

    // T5: reset pulse while reads are in flight; RAM contents survive.
    rd_en = 1'b0; rd_addr = AW'(BASE);
    step();
    rd_addr = AW'(10);
    step();
    rd_en = 1'b1; reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    repeat (4) step();
    do_read(BASE);
    repeat (4) step();

    // Preload the random address pool, then random traffic.
    for (int a = BASE; a < BASE + 16; a++) do_write(a, $urandom);
    do_write(LAST - 1, $urandom);
    for (int i = 0; i < 400; i++) begin
      if (wr_en && ($urandom_range(1, 0) == 1)) begin
        wr_en = 1'b0; wr_addr = AW'(rand_addr()); wr_data = $urandom;
      end
      if (rd_en && ($urandom_range(1, 0) == 1)) begin
        rd_en = 1'b0; rd_addr = AW'(rand_addr());
      end
      step();
      if (last_aw) wr_en = 1'b1;
      if (last_ar) rd_en = 1'b1;
    end
    wr_en = 1'b1; rd_en = 1'b1;
    repeat (LAT + 4) step();
    check("scoreboard_drained", q.size(), 0);

`ifdef MEM_RESP_STALL_EN
    // T6: write held low for 1000 cycles under random stalls.
    begin
      int acc = 0;
      int a = BASE + 100;
      wr_en = 1'b0; wr_addr = AW'(a); wr_data = $urandom;
      for (int i = 0; i < 1000; i++) begin
        step();
        if (last_aw) begin
          acc++; a++;
          wr_addr = AW'(a); wr_data = $urandom;
        end
      end
      wr_en = 1'b1;
      check("stall_accepts_ge_700", acc >= 700, 1);
      check("stall_accepts_le_800", acc <= 800, 1);
      for (int k = 0; k < 8; k++) do_read(BASE + 100 + k * 50);
      repeat (LAT + 4) step();
      check("stall_scoreboard_drained", q.size(), 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
